// File: rtl/div_share_ctrl.sv
// rtl/div_share_ctrl.sv - round-robin sequencer sharing one external signed 8/4 divider
// Requests are granted one at a time; results return on a single tagged response channel.
module div_share_ctrl #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [8*NREQ-1:0]    req_dividend,
    input  logic [4*NREQ-1:0]    req_divisor,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_id,
    output logic [7:0]           rsp_quotient,
    output logic [3:0]           rsp_remainder,
    output logic                 rsp_dbz,
    output logic [7:0]           div_dividend,
    output logic [3:0]           div_divisor,
    input  logic [7:0]           div_quotient,
    input  logic [3:0]           div_remainder
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  last_grant;
    logic [1:0]  grant_id;
    logic        grant_found;
    logic [2:0]  cand_sum;
    logic [1:0]  cand;
    logic        accept;
    logic [7:0]  sel_dividend;
    logic [3:0]  sel_divisor;
    logic [1:0]  op_id;
    logic [7:0]  op_dividend;
    logic [3:0]  op_divisor;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand_sum    = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_sum = {1'b0, last_grant} + 3'(k);
            if (cand_sum >= 3'(NREQ)) begin
                cand_sum = cand_sum - 3'(NREQ);
            end
            cand = cand_sum[1:0];
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == 2'(i)) begin
                sel_dividend = req_dividend[8*i +: 8];
                sel_divisor  = req_divisor[4*i +: 4];
            end
        end
    end

    // rst_n gates the ready so nothing looks accepted while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign accept = (state == IDLE) && grant_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant    <= 2'(NREQ - 1);
            op_id         <= '0;
            op_dividend   <= '0;
            op_divisor    <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_dbz       <= 1'b0;
        end else begin
            if (accept) begin
                op_id       <= grant_id;
                op_dividend <= sel_dividend;
                op_divisor  <= sel_divisor;
                last_grant  <= grant_id;
            end
            if (state == ISSUE) begin
                rsp_valid <= 1'b1;
                rsp_id    <= op_id;
                // A zero divisor never lets the divider's output reach the response.
                if (op_divisor == 4'd0) begin
                    rsp_quotient  <= '0;
                    rsp_remainder <= '0;
                    rsp_dbz       <= 1'b1;
                end else begin
                    rsp_quotient  <= div_quotient;
                    rsp_remainder <= div_remainder;
                    rsp_dbz       <= 1'b0;
                end
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign div_dividend = op_dividend;
    assign div_divisor  = op_divisor;

endmodule

// File: tb/tb_div_share_ctrl.sv
// tb/tb_div_share_ctrl.sv - scoreboard bench for div_share_ctrl with a behavioural divider
module tb_div_share_ctrl;

    localparam int N = 4;
    typedef logic [14:0] ent_t;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [8*N-1:0]  req_dividend;
    logic [4*N-1:0]  req_divisor;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [7:0]      rsp_quotient;
    logic [3:0]      rsp_remainder;
    logic            rsp_dbz;
    logic [7:0]      div_dividend;
    logic [3:0]      div_divisor;
    logic [7:0]      div_quotient;
    logic [3:0]      div_remainder;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    ent_t exp_q[$];
    ent_t got_q[$];
    int   grant_q[$];
    int   grant_cyc[$];

    div_share_ctrl #(.NREQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_dividend(req_dividend), .req_divisor(req_divisor),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_dbz(rsp_dbz),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Floor quotient; zero divisor returns junk that must never reach the response.
    function automatic logic [11:0] div_fn(input logic [7:0] a, input logic [3:0] b);
        int ai, bi, qi, ri;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) return 12'hA5A;
        qi = ai / bi;
        ri = ai - qi * bi;
        if (ri != 0 && ((ri < 0) != (bi < 0))) begin
            qi = qi - 1;
            ri = ri + bi;
        end
        return {qi[7:0], ri[3:0]};
    endfunction

    function automatic ent_t make_exp(input logic [1:0] id, input logic [7:0] a, input logic [3:0] b);
        if (b == 4'd0) return {id, 8'd0, 4'd0, 1'b1};
        return {id, div_fn(a, b), 1'b0};
    endfunction

    always_comb {div_quotient, div_remainder} = div_fn(div_dividend, div_divisor);

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_q.push_back(make_exp(2'(i), req_dividend[8*i +: 8], req_divisor[4*i +: 4]));
                    grant_q.push_back(i);
                    grant_cyc.push_back(cyc);
                end
            end
            if (rsp_valid && rsp_ready)
                got_q.push_back({rsp_id, rsp_quotient, rsp_remainder, rsp_dbz});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] a, input logic [3:0] b);
        req_valid[i] = v;
        req_dividend[8*i +: 8] = a;
        req_divisor[4*i +: 4] = b;
    endtask

    task automatic send(input int i, input logic [7:0] a, input logic [3:0] b);
        int t = 0;
        set_req(i, 1'b1, a, b);
        while (!req_ready[i] && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!req_ready[i]) begin
            errors++;
            $display("FAIL send_grant req %0d never granted (req_ready=%b)", i, req_ready);
        end
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_got(input int n, input string name);
        int t = 0;
        while (got_q.size() < n && t < 300) begin
            @(negedge clk);
            #1;
            t++;
        end
        checks++;
        if (got_q.size() < n) begin
            errors++;
            $display("FAIL %s_timeout responses %0d required %0d", name, got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'd5, 4'd1);
        #12;
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        checks++;
        if ({rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz} !== 16'h0) begin
            errors++;
            $display("FAIL reset_rsp got %h want 0000", {rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz});
        end
        checks++;
        if ({div_dividend, div_divisor} !== 12'h0) begin
            errors++; $display("FAIL reset_div got %h want 000", {div_dividend, div_divisor});
        end
        req_valid = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        ent_t g, e;
        set_req(1, 1'b1, 8'd7, 4'd2);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_grant got %b want 0010", req_ready); end
        tick();
        req_valid[1] = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, req_ready, div_dividend, div_divisor} !== {1'b0, 4'b0, 8'd7, 4'd2}) begin
            errors++;
            $display("FAIL single_issue got v=%b rdy=%b op=%h/%h want v=0 rdy=0000 op=07/2",
                     rsp_valid, req_ready, div_dividend, div_divisor);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz} !== {1'b1, 2'd1, 8'd3, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL single_rsp got v=%b id=%0d q=%h r=%h dbz=%b want v=1 id=1 q=03 r=1 dbz=0",
                     rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz);
        end
        wait_got(1, "single");
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL single_sb got %h want %h", g, e); end
        end
    endtask

    task automatic test_negative();
        ent_t g, e;
        tick();
        set_req(0, 1'b1, 8'hF9, 4'd2);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL neg_grant got %b want 0001", req_ready); end
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({div_dividend, div_divisor} !== {8'hF9, 4'h2}) begin
            errors++; $display("FAIL neg_issue got %h/%h want F9/2", div_dividend, div_divisor);
        end
        wait_got(1, "neg");
        g = got_q.pop_front(); e = exp_q.pop_front();
        checks++;
        if (g !== {2'd0, 8'hFC, 4'h1, 1'b0}) begin errors++; $display("FAIL neg_rsp got %h want %h", g, {2'd0, 8'hFC, 4'h1, 1'b0}); end
        checks++;
        if (g !== e) begin errors++; $display("FAIL neg_sb got %h want %h", g, e); end
    endtask

    task automatic test_dbz();
        ent_t g, e;
        tick();
        send(2, 8'd100, 4'd0);
        send(2, 8'd100, 4'd3);
        wait_got(2, "dbz");
        g = got_q.pop_front(); e = exp_q.pop_front();
        checks++;
        if (g !== {2'd2, 8'd0, 4'd0, 1'b1} || g !== e) begin
            errors++; $display("FAIL dbz_zero got %h want %h", g, {2'd2, 8'd0, 4'd0, 1'b1});
        end
        g = got_q.pop_front(); e = exp_q.pop_front();
        checks++;
        if (g !== {2'd2, 8'd33, 4'd1, 1'b0} || g !== e) begin
            errors++; $display("FAIL dbz_next got %h want %h", g, {2'd2, 8'd33, 4'd1, 1'b0});
        end
    endtask

    task automatic test_backpressure();
        ent_t g, e;
        logic [15:0] snap;
        int t = 0;
        tick();
        rsp_ready = 1'b0;
        send(3, 8'd50, 4'd7);
        set_req(3, 1'b1, 8'hEC, 4'd3);
        while (!rsp_valid && t < 10) begin @(negedge clk); t++; end
        snap = {rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz};
        checks++;
        if (snap !== {1'b1, 2'd3, 8'd7, 4'd1, 1'b0}) begin
            errors++; $display("FAIL bp_first got %h want %h", snap, {1'b1, 2'd3, 8'd7, 4'd1, 1'b0});
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz} !== snap || req_ready !== 4'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got rsp=%h rdy=%b want rsp=%h rdy=0000", k,
                         {rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz}, req_ready, snap);
            end
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_regrant got %b want 1000", req_ready); end
        tick();
        req_valid[3] = 1'b0;
        wait_got(2, "bp");
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL bp_sb got %h want %h", g, e); end
        end
    endtask

    task automatic test_fairness();
        ent_t g, e;
        int t = 0;
        rst_n = 1'b0;
        #7 rst_n = 1'b1;
        exp_q.delete(); got_q.delete(); grant_q.delete(); grant_cyc.delete();
        tick();
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(i * 20 + 9), 4'(i + 2));
        while (grant_q.size() < 6 && t < 60) begin @(negedge clk); #1; t++; end
        tick();
        req_valid = '0;
        wait_got(6, "fair");
        for (int k = 0; k < 6 && k < grant_q.size(); k++) begin
            checks++;
            if (grant_q[k] != k % N) begin errors++; $display("FAIL fair_order slot %0d got %0d want %0d", k, grant_q[k], k % N); end
            if (k > 0) begin
                checks++;
                if (grant_cyc[k] - grant_cyc[k-1] != 3) begin
                    errors++; $display("FAIL fair_rate slot %0d gap %0d want 3", k, grant_cyc[k] - grant_cyc[k-1]);
                end
            end
        end
        for (int k = 0; k < 6 && got_q.size() > 0 && exp_q.size() > 0; k++) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g !== e || g[14:13] !== 2'(k % N)) begin errors++; $display("FAIL fair_rsp got %h want %h", g, e); end
        end
        grant_q.delete(); grant_cyc.delete();
    endtask

    task automatic test_reset_midop();
        ent_t g, e;
        int t = 0;
        tick();
        rsp_ready = 1'b1;
        set_req(2, 1'b1, 8'd90, 4'd4);
        while (!req_ready[2] && t < 20) begin @(negedge clk); t++; end
        @(posedge clk);
        #3 rst_n = 1'b0;
        req_valid = '0;
        #1;
        checks++;
        if ({rsp_valid, div_dividend, div_divisor, req_ready} !== 17'h0) begin
            errors++; $display("FAIL midop_reset got v=%b op=%h/%h rdy=%b want all 0", rsp_valid, div_dividend, div_divisor, req_ready);
        end
        exp_q.delete(); got_q.delete(); grant_q.delete(); grant_cyc.delete();
        #4 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midop_stale cycle %0d rsp_valid got %b want 0", k, rsp_valid); end
        end
        tick();
        set_req(0, 1'b1, 8'd12, 4'd5);
        set_req(1, 1'b1, 8'd13, 4'd6);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL midop_first got %b want 0001", req_ready); end
        tick();
        req_valid[0] = 1'b0;
        t = 0;
        while (!req_ready[1] && t < 20) begin @(negedge clk); t++; end
        tick();
        req_valid[1] = 1'b0;
        wait_got(2, "midop");
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL midop_sb got %h want %h", g, e); end
        end
        grant_q.delete(); grant_cyc.delete();
    endtask

    task automatic test_back_to_back();
        ent_t g, e;
        bit done = 1'b0;
        tick();
        fork
            begin
                for (int k = 0; k < 16; k++) begin
                    if (k == 5) send(1, 8'h80, 4'hF);
                    else send(int'($urandom_range(0, N - 1)), 8'($urandom), 4'($urandom_range(0, 7)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tick();
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        rsp_ready = 1'b1;
        wait_got(16, "b2b");
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL b2b_sb got %h want %h", g, e); end
        end
    endtask

    initial begin
        req_valid = '0;
        req_dividend = '0;
        req_divisor = '0;
        rsp_ready = 1'b1;
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_negative();
        test_dbz();
        test_backpressure();
        test_fairness();
        test_reset_midop();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
